// File: rtl/cpu_pkg.sv
// Shared CPU types and constants; also carries the ROM loader's state type and frame marker.
package cpu_pkg;

    localparam int         ROM_SIZE  = 8;
    localparam int         WORD_SIZE = 11;
    localparam logic [7:0] HDR_BYTE  = 8'hA5;

    typedef logic [WORD_SIZE-1:0] word;
    typedef logic [2:0]           exec_opts;
    typedef logic [1:0]           alu_op;
    typedef logic [2:0]           register_name;

    typedef struct packed {
        exec_opts     exec;
        alu_op        op;
        register_name r;
        register_name write_to;
    } instruction;

    typedef struct packed {
        logic       clk;
        logic [7:0] data;
    } io_bus;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_COUNT,
        LD_HI,
        LD_LO,
        LD_CSUM,
        LD_DONE,
        LD_ERR
    } loader_state;

endpackage

// File: rtl/bus_strobe_sync.sv
// Brings the asynchronous io_bus strobe into the core clock domain and turns
// each rising edge into a single-cycle accept pulse.
module bus_strobe_sync #(
    parameter int SYNC_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic pulse
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], strobe};
            prev_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign pulse = sync_q[SYNC_DEPTH-1] & ~prev_q;

endmodule

// File: rtl/rom_loader.sv
// Writer side of the instruction ROM: parses a byte-serial program frame and
// writes one 11-bit instruction per word, holding the CPU until the load ends.
module rom_loader
    import cpu_pkg::*;
#(
    parameter int         ROM_SIZE   = cpu_pkg::ROM_SIZE,
    parameter int         SYNC_DEPTH = 2,
    parameter logic [7:0] HDR_BYTE   = cpu_pkg::HDR_BYTE,
    localparam int        AW         = $clog2(ROM_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8:0]           io_in,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [WORD_SIZE-1:0] wr_data,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error,
    output logic [AW:0]          words_left
);

    localparam logic [8:0] MAX_N = 9'(ROM_SIZE);

    io_bus       bus;
    logic        accept;
    logic [7:0]  byte_in;
    loader_state state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [AW:0]   words_left_q;
    logic [7:0]  csum_q;
    logic [2:0]  hi_q;
    logic        is_hdr, count_bad, hi_bad, last_word;

    assign bus     = io_in;
    assign byte_in = bus.data;

    bus_strobe_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .strobe (bus.clk),
        .pulse  (accept)
    );

    assign is_hdr     = (byte_in == HDR_BYTE);
    assign count_bad  = (byte_in == 8'd0) || ({1'b0, byte_in} > MAX_N);
    assign hi_bad     = |byte_in[7:3];
    assign last_word  = (words_left_q == (AW+1)'(1));
    assign words_left = words_left_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= LD_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE, LD_ERR: if (accept && is_hdr) state_d = LD_COUNT;
            LD_COUNT:        if (accept) state_d = count_bad ? LD_ERR : LD_HI;
            LD_HI:           if (accept) state_d = hi_bad ? LD_ERR : LD_LO;
            LD_LO:           if (accept) state_d = last_word ? LD_CSUM : LD_HI;
            LD_CSUM:         if (accept) state_d = (byte_in == csum_q) ? LD_DONE : LD_ERR;
            default:         state_d = LD_IDLE;
        endcase
    end

    // Status is purely a function of state: error persists exactly as long as ERR does.
    always_comb begin
        cpu_hold = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            LD_COUNT, LD_HI, LD_LO, LD_CSUM: cpu_hold = 1'b1;
            LD_DONE:                         done     = 1'b1;
            LD_ERR:                          error    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            words_left_q <= '0;
            csum_q       <= '0;
            hi_q         <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                case (state_q)
                    LD_IDLE, LD_ERR: if (is_hdr) csum_q <= '0;
                    LD_COUNT: begin
                        csum_q <= csum_q ^ byte_in;
                        if (!count_bad) begin
                            words_left_q <= byte_in[AW:0];
                            addr_q       <= '0;
                        end
                    end
                    LD_HI: begin
                        csum_q <= csum_q ^ byte_in;
                        hi_q   <= byte_in[2:0];
                    end
                    LD_LO: begin
                        csum_q       <= csum_q ^ byte_in;
                        wr_en        <= 1'b1;
                        wr_addr      <= addr_q;
                        wr_data      <= {hi_q, byte_in};
                        words_left_q <= words_left_q - 1'b1;
                        // Stop at the last slot so the address never wraps past ROM_SIZE-1.
                        if (!last_word) addr_q <= addr_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed frames plus randomized frames
// compared against a byte-list parser model of the frame format.
module tb_rom_loader;
    import cpu_pkg::*;

    localparam int AW = 3;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  io_in;
    logic        wr_en;
    logic [AW-1:0] wr_addr;
    logic [10:0] wr_data;
    logic        cpu_hold, done, error;
    logic [AW:0] words_left;

    always #5 clk = ~clk;

    rom_loader #(.ROM_SIZE(8), .SYNC_DEPTH(2), .HDR_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .io_in      (io_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .words_left (words_left)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: records every ROM write and done pulse, and flags back-to-back writes.
    wr_t cap[$];
    wr_t mon_t;
    int  done_cnt = 0;
    int  back_to_back = 0;
    bit  prev_wr = 0;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            mon_t.addr = wr_addr;
            mon_t.data = wr_data;
            cap.push_back(mon_t);
            if (prev_wr) back_to_back++;
        end
        if (done === 1'b1) done_cnt++;
        prev_wr = (wr_en === 1'b1);
    end

    task automatic send_byte(input logic [7:0] b, input int high = 3);
        @(negedge clk);
        io_in = {1'b1, b};
        repeat (high) @(negedge clk);
        io_in[8] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Reference model: walks a byte list by the frame rules, tracking error/hold across calls.
    bit  m_err = 0, m_hold = 0;
    wr_t exp_wr[$];
    int  exp_done;

    task automatic model(input bytes_t b);
        int i = 0;
        int n = b.size();
        exp_wr.delete();
        exp_done = 0;
        while (i < n) begin
            logic [7:0] cnt, c, hi;
            bit bad;
            wr_t t;
            if (b[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            m_err = 0;
            m_hold = 1;
            if (i >= n) return;
            cnt = b[i];
            i++;
            c = cnt;
            if (cnt == 0 || cnt > 8) begin
                m_err = 1;
                m_hold = 0;
                continue;
            end
            bad = 0;
            for (int w = 0; w < int'(cnt); w++) begin
                if (i >= n) return;
                hi = b[i];
                i++;
                c ^= hi;
                if (hi[7:3] != 0) begin
                    bad = 1;
                    break;
                end
                if (i >= n) return;
                t.addr = w;
                t.data = {hi[2:0], b[i]};
                c ^= b[i];
                i++;
                exp_wr.push_back(t);
            end
            if (bad) begin
                m_err = 1;
                m_hold = 0;
                continue;
            end
            if (i >= n) return;
            if (b[i] == c) exp_done++;
            else m_err = 1;
            m_hold = 0;
            i++;
        end
    endtask

    task automatic run_frame(input string tag, input bytes_t b);
        cap.delete();
        done_cnt = 0;
        foreach (b[k]) send_byte(b[k]);
        repeat (4) @(negedge clk);
        model(b);
        check($sformatf("%s/nwr", tag), cap.size(), exp_wr.size());
        for (int k = 0; k < cap.size() && k < exp_wr.size(); k++) begin
            check($sformatf("%s/addr%0d", tag, k), cap[k].addr, exp_wr[k].addr);
            check($sformatf("%s/data%0d", tag, k), cap[k].data, exp_wr[k].data);
        end
        check($sformatf("%s/done", tag), done_cnt, exp_done);
        check($sformatf("%s/error", tag), error, m_err);
        check($sformatf("%s/hold", tag), cpu_hold, m_hold);
    endtask

    // kind: 0 good, 1 bad checksum, 2 bad HI byte, 3 bad count
    function automatic bytes_t make_frame(input int n, input int kind);
        bytes_t f;
        logic [7:0] c, hi, lo;
        int bad_w = $urandom_range(n - 1, 0);
        for (int k = $urandom_range(2, 0); k > 0; k--) begin
            lo = 8'($urandom_range(255, 0));
            f.push_back(lo == 8'hA5 ? 8'h00 : lo);
        end
        f.push_back(8'hA5);
        if (kind == 3) begin
            f.push_back($urandom_range(1, 0) ? 8'h00 : 8'($urandom_range(255, 9)));
            return f;
        end
        c = 8'(n);
        f.push_back(c);
        for (int w = 0; w < n; w++) begin
            hi = 8'($urandom_range(7, 0));
            if (kind == 2 && w == bad_w) begin
                hi[7:3] = 5'($urandom_range(31, 1));
                f.push_back(hi);
                return f;
            end
            lo = 8'($urandom_range(255, 0));
            f.push_back(hi);
            f.push_back(lo);
            c = c ^ hi ^ lo;
        end
        f.push_back(kind == 1 ? (c ^ 8'($urandom_range(255, 1))) : c);
        return f;
    endfunction

    initial begin
        bytes_t f;
        rst = 1'b1;
        io_in = '0;
        repeat (3) @(negedge clk);
        check("rst/wr_en", wr_en, 0);
        check("rst/hold", cpu_hold, 0);
        check("rst/done", done, 0);
        check("rst/error", error, 0);
        check("rst/words_left", words_left, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: two-word good frame
        run_frame("t1", '{8'hA5, 8'h02, 8'h05, 8'h3C, 8'h00, 8'h81, 8'hBA});
        if (cap.size() == 2) begin
            check("t1/word0", cap[0].data, 11'h53C);
            check("t1/word1", cap[1].data, 11'h081);
        end else check("t1/count", cap.size(), 2);

        // 2: bad checksum, then a good frame clears error on its header
        run_frame("t2a", '{8'hA5, 8'h03, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 8'h00});
        cap.delete();
        done_cnt = 0;
        send_byte(8'hA5);
        check("t2/err_clr", error, 0);
        check("t2/hold_hdr", cpu_hold, 1);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h23);
        send_byte(8'h23);
        check("t2/done", done_cnt, 1);
        check("t2/nwr", cap.size(), 1);
        if (cap.size() > 0) check("t2/data", cap[0].data, 11'h123);
        m_err = 0;
        m_hold = 0;

        // 3: count out of range
        run_frame("t3_n0", '{8'hA5, 8'h00});
        run_frame("t3_n9", '{8'hA5, 8'h09});

        // 4: bad HI byte on word 1
        run_frame("t4", '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h08});

        // 5: noise ignored, long strobe accepted once
        cap.delete();
        done_cnt = 0;
        send_byte(8'h00);
        check("t5/hold_n0", cpu_hold, 0);
        send_byte(8'hFF);
        check("t5/hold_nff", cpu_hold, 0);
        send_byte(8'hA5, 20);
        check("t5/hold_hdr", cpu_hold, 1);
        send_byte(8'h01);
        check("t5/words_left", words_left, 1);
        check("t5/error", error, 0);
        send_byte(8'h00);
        send_byte(8'h07);
        send_byte(8'h06);
        check("t5/done", done_cnt, 1);
        check("t5/hold_end", cpu_hold, 0);
        check("t5/wl_end", words_left, 0);
        m_err = 0;
        m_hold = 0;

        // 6: reset between HI and LO of word 2
        cap.delete();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h02);
        check("t6/words_left", words_left, 2);
        rst = 1'b1;
        @(negedge clk);
        check("t6/wr_en", wr_en, 0);
        check("t6/hold", cpu_hold, 0);
        check("t6/error", error, 0);
        check("t6/done", done, 0);
        check("t6/words_left0", words_left, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t6/no_more_wr", cap.size(), 1);
        m_err = 0;
        m_hold = 0;
        run_frame("t6_reload", '{8'hA5, 8'h01, 8'h04, 8'h56, 8'h53});

        // randomized frames of every kind
        for (int it = 0; it < 40; it++) begin
            f = make_frame($urandom_range(8, 1), $urandom_range(3, 0));
            run_frame($sformatf("rnd%0d", it), f);
        end

        check("wr_en_spacing", back_to_back, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
